// File: rtl/ascon_output_serializer.sv
// Buffers ASCON ciphertext blocks and the tag, then streams them as OUT_W-bit chunks over valid/ready.
// Optional macro ASCON_SER_HEADER_EN prepends a {overflow, 3'b000, count} header chunk.
module ascon_output_serializer #(
  parameter int NB_BLOCKS = 3,
  parameter int OUT_W     = 8
) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [63:0]      cipher_i,
  input  logic             cipher_valid_i,
  input  logic [127:0]     tag_i,
  input  logic             end_i,
  output logic [OUT_W-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             dout_last_o,
  output logic             busy_o,
  output logic             overflow_o
);

  localparam int CPB   = 64 / OUT_W;
  localparam int TPC   = 128 / OUT_W;
  localparam int IDX_W = $clog2(TPC + 1);
  localparam int BW    = $clog2(NB_BLOCKS + 1);

  typedef enum logic [2:0] {COLLECT, SEND_HDR, SEND_CIPHER, SEND_TAG, DONE} state_t;

  state_t             state, state_nxt;
  logic [63:0]        buffer [NB_BLOCKS];
  logic [127:0]       tag_q;
  logic [BW-1:0]      count;
  logic [BW-1:0]      count_fin;
  logic [BW-1:0]      count_eff;
  logic               pend;
  logic [IDX_W-1:0]   chunk;
  logic [BW-1:0]      blk;
  logic               hs;
  logic [63:0]        cipher_sh;
  logic [127:0]       tag_sh;

  // A pending capture lands this cycle, so it already counts toward end-of-message and overflow.
  assign count_fin = count + BW'(pend);
  assign count_eff = start_i ? '0 : count_fin;
  assign hs        = (state == SEND_HDR || state == SEND_CIPHER || state == SEND_TAG) && dout_ready_i;
  assign busy_o    = (state != COLLECT);
  assign cipher_sh = buffer[blk] >> (OUT_W * (CPB - 1 - int'(chunk)));
  assign tag_sh    = tag_q >> (OUT_W * (TPC - 1 - int'(chunk)));

`ifdef ASCON_SER_HEADER_EN
  logic [3:0] cnt4;
  assign cnt4 = 4'(count);
`endif

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) state <= COLLECT;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    dout_valid_o = 1'b0;
    dout_last_o  = 1'b0;
    dout_o       = '0;
    case (state)
      COLLECT: begin
        if (end_i) begin
`ifdef ASCON_SER_HEADER_EN
          state_nxt = SEND_HDR;
`else
          state_nxt = (count_fin != '0) ? SEND_CIPHER : SEND_TAG;
`endif
        end
      end
`ifdef ASCON_SER_HEADER_EN
      SEND_HDR: begin
        dout_valid_o = 1'b1;
        dout_o       = OUT_W'({overflow_o, 3'b000, cnt4});
        if (hs) state_nxt = (count != '0) ? SEND_CIPHER : SEND_TAG;
      end
`endif
      SEND_CIPHER: begin
        dout_valid_o = 1'b1;
        dout_o       = cipher_sh[OUT_W-1:0];
        if (hs && chunk == IDX_W'(CPB - 1) && blk == count - BW'(1)) state_nxt = SEND_TAG;
      end
      SEND_TAG: begin
        dout_valid_o = 1'b1;
        dout_o       = tag_sh[OUT_W-1:0];
        dout_last_o  = (chunk == IDX_W'(TPC - 1));
        if (hs && dout_last_o) state_nxt = DONE;
      end
      DONE:    state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // Buffer contents are don't-care after reset, so no reset branch here.
  always_ff @(posedge clock_i) begin
    if (state == COLLECT && pend && !start_i) buffer[count] <= cipher_i;
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count      <= '0;
      pend       <= 1'b0;
      overflow_o <= 1'b0;
      chunk      <= '0;
      blk        <= '0;
      tag_q      <= '0;
    end else begin
      case (state)
        COLLECT: begin
          pend <= 1'b0;
          if (start_i) begin
            count      <= '0;
            overflow_o <= 1'b0;
          end else if (pend) begin
            count <= count + BW'(1);
          end
          if (cipher_valid_i && !end_i) begin
            if (count_eff == BW'(NB_BLOCKS)) overflow_o <= 1'b1;
            else                             pend       <= 1'b1;
          end
          if (end_i) begin
            tag_q <= tag_i;
            chunk <= '0;
            blk   <= '0;
          end
        end
        SEND_CIPHER: begin
          if (hs) begin
            if (chunk == IDX_W'(CPB - 1)) begin
              chunk <= '0;
              blk   <= blk + BW'(1);
            end else begin
              chunk <= chunk + IDX_W'(1);
            end
          end
        end
        SEND_TAG: if (hs) chunk <= chunk + IDX_W'(1);
        DONE:     count <= '0;
        default:  ;
      endcase
      if (state != COLLECT && cipher_valid_i) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ascon_output_serializer.sv
// Directed bench for ascon_output_serializer (OUT_W=8, NB_BLOCKS=3); follows ASCON_SER_HEADER_EN if defined.
module tb_ascon_output_serializer;

  logic         clock_i = 1'b0;
  logic         resetb_i = 1'b0;
  logic         start_i = 1'b0;
  logic [63:0]  cipher_i = '0;
  logic         cipher_valid_i = 1'b0;
  logic [127:0] tag_i = '0;
  logic         end_i = 1'b0;
  logic [7:0]   dout_o;
  logic         dout_valid_o;
  logic         dout_ready_i = 1'b1;
  logic         dout_last_o;
  logic         busy_o;
  logic         overflow_o;

  ascon_output_serializer #(.NB_BLOCKS(3), .OUT_W(8)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .cipher_i(cipher_i),
    .cipher_valid_i(cipher_valid_i), .tag_i(tag_i), .end_i(end_i), .dout_o(dout_o),
    .dout_valid_o(dout_valid_o), .dout_ready_i(dout_ready_i), .dout_last_o(dout_last_o),
    .busy_o(busy_o), .overflow_o(overflow_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0]  blk_in [4] = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF,
                               64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D};
  logic [127:0] tag_val = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  logic [7:0] got_b  [64];
  logic       got_l  [64];
  int         got_n;
  logic [7:0] exp_b  [64];
  int         exp_n;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int nblk, input logic [7:0] hdr);
    logic [63:0] b;
    exp_n = 0;
`ifdef ASCON_SER_HEADER_EN
    exp_b[exp_n] = hdr; exp_n++;
`else
    if (hdr == 8'hFF) exp_n = 0;
`endif
    for (int i = 0; i < nblk; i++) begin
      b = blk_in[i];
      for (int j = 0; j < 8; j++) begin exp_b[exp_n] = b[63-8*j -: 8]; exp_n++; end
    end
    for (int j = 0; j < 16; j++) begin exp_b[exp_n] = tag_val[127-8*j -: 8]; exp_n++; end
  endtask

  // Leaves end_i asserted; stream() deasserts it on the following cycle.
  task automatic drive_msg(input int npulse);
    @(negedge clock_i); start_i = 1'b1;
    @(negedge clock_i); start_i = 1'b0;
    for (int i = 0; i < npulse; i++) begin
      cipher_valid_i = 1'b1;
      @(negedge clock_i); cipher_valid_i = 1'b0; cipher_i = blk_in[i];
      @(negedge clock_i);
    end
    end_i = 1'b1; tag_i = tag_val;
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0 repeating. Stops at last chunk or stop_at bytes.
  task automatic stream(input string name, input int mode, input int stop_at);
    logic [8:0] held;
    logic       stalled = 1'b0;
    logic       done = 1'b0;
    int         gaps = 0;
    got_n = 0;
    @(negedge clock_i); end_i = 1'b0;
    for (int c = 0; c < 400; c++) begin
      dout_ready_i = (mode == 0) ? 1'b1 : (c % 3 == 0);
      #1;
      if (c == 0) check({name, "_vld_lat"}, dout_valid_o, 1'b1);
      if (stalled) check({name, "_stable"}, {dout_last_o, dout_o}, held);
      stalled = dout_valid_o && !dout_ready_i;
      held    = {dout_last_o, dout_o};
      if (!dout_valid_o && got_n > 0) gaps++;
      if (dout_valid_o && dout_ready_i) begin
        got_b[got_n] = dout_o; got_l[got_n] = dout_last_o; got_n++;
        if (dout_last_o || got_n == stop_at) begin done = 1'b1; break; end
      end
      @(negedge clock_i);
    end
    dout_ready_i = 1'b1;
    if (!done) check({name, "_timeout"}, 1'b0, 1'b1);
    if (mode == 0) check({name, "_gaps"}, gaps, 0);
  endtask

  task automatic compare(input string name);
    check({name, "_count"}, got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      check($sformatf("%s_byte%0d", name, i), got_b[i], exp_b[i]);
      check($sformatf("%s_last%0d", name, i), got_l[i], (i == exp_n - 1));
    end
  endtask

  initial begin
    #1;
    check("rst_valid", dout_valid_o, 1'b0);
    check("rst_dout", dout_o, 8'h00);
    check("rst_last", dout_last_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    @(negedge clock_i); resetb_i = 1'b1;

    // Nominal three-block message
    drive_msg(3);
    stream("nom", 0, 64);
    build_exp(3, 8'h03);
    compare("nom");
    @(negedge clock_i); check("nom_busy_done", busy_o, 1'b1);
    @(negedge clock_i); check("nom_busy_idle", busy_o, 1'b0);

    // Backpressure
    drive_msg(3);
    stream("bp", 1, 64);
    compare("bp");
    repeat (3) @(negedge clock_i);

    // Overflow: fourth block dropped
    drive_msg(4);
    stream("ovf", 0, 64);
    build_exp(3, 8'h83);
    compare("ovf");
    repeat (3) @(negedge clock_i);
    check("ovf_sticky", overflow_o, 1'b1);

    // Tag only (start clears overflow)
    drive_msg(0);
    #1 check("ovf_cleared", overflow_o, 1'b0);
    stream("tag", 0, 64);
    build_exp(0, 8'h00);
    compare("tag");
    repeat (3) @(negedge clock_i);

    // Reset mid-transfer
    drive_msg(3);
    stream("pre", 0, 10);
    @(posedge clock_i); #2 resetb_i = 1'b0;
    #1;
    check("mid_rst_valid", dout_valid_o, 1'b0);
    check("mid_rst_dout", dout_o, 8'h00);
    check("mid_rst_last", dout_last_o, 1'b0);
    check("mid_rst_busy", busy_o, 1'b0);
    @(negedge clock_i); resetb_i = 1'b1;
    drive_msg(1);
    stream("post", 0, 64);
    build_exp(1, 8'h01);
    compare("post");
    repeat (3) @(negedge clock_i);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
